// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } sar_state_e;

  // One-hot comparator result encoding, ordered {gt, eq, lt}.
  localparam logic [2:0] CmpGt = 3'b100;
  localparam logic [2:0] CmpEq = 3'b010;
  localparam logic [2:0] CmpLt = 3'b001;

  // Width of the per-compare wait counter; TIMEOUT must not exceed 2**TmoCntW.
  localparam int unsigned TmoCntW = 16;

endpackage

// File: rtl/sar_cmp_decode.sv
// Decodes the {gt, eq, lt} comparator result into keep-bit, exact-hit and invalid flags.
module sar_cmp_decode
  import sar_pkg::*;
(
  input  logic gt,
  input  logic eq,
  input  logic lt,
  output logic keep,
  output logic hit,
  output logic bad
);

  always_comb begin
    keep = 1'b0;
    hit  = 1'b0;
    bad  = 1'b0;
    case ({gt, eq, lt})
      CmpGt: keep = 1'b1;
      CmpEq: begin
        keep = 1'b1;
        hit  = 1'b1;
      end
      CmpLt: ;
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller driving an external magnitude comparator.
// Optional early exit on an exact match is enabled by defining SAR_EARLY_EXIT_EN.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [WIDTH-1:0] trial,
  output logic             cmp_req,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  input  logic             cmp_valid
);

  localparam int unsigned         IdxW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0]     IdxTop  = IdxW'(WIDTH - 1);
  localparam logic [TmoCntW-1:0]  TmoLast = TmoCntW'(TIMEOUT - 1);
`ifdef SAR_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  sar_state_e         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [TmoCntW-1:0] tmo_q, tmo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic               keep, hit, bad;
  logic [WIDTH-1:0]   trial_w, acc_bit, fin_val;
  logic               finish, fin_err;

  assign trial_w = acc_q | (WIDTH'(1) << idx_q);
  assign acc_bit = keep ? trial_w : acc_q;

  sar_cmp_decode u_decode (
    .gt   (cmp_gt),
    .eq   (cmp_eq),
    .lt   (cmp_lt),
    .keep (keep),
    .hit  (hit),
    .bad  (bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      idx_q    <= IdxTop;
      tmo_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;
    finish   = 1'b0;
    fin_err  = 1'b0;
    fin_val  = acc_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StReq;
          acc_d   = '0;
          idx_d   = IdxTop;
          tmo_d   = '0;
          err_d   = 1'b0;
        end
      end
      StReq: begin
        if (cmp_valid) begin
          tmo_d = '0;
          if (bad) begin
            // Undecided bits of the accumulator are still zero, so it is the partial result.
            finish  = 1'b1;
            fin_err = 1'b1;
          end else if (EarlyExit && hit) begin
            finish  = 1'b1;
            fin_val = trial_w;
          end else if (idx_q == '0) begin
            finish  = 1'b1;
            fin_val = acc_bit;
          end else begin
            acc_d = acc_bit;
            idx_d = idx_q - 1'b1;
          end
        end else if (TIMEOUT != 0 && tmo_q == TmoLast) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else if (TIMEOUT != 0) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (finish) begin
      state_d  = StDone;
      result_d = fin_val;
      err_d    = fin_err;
      done_d   = 1'b1;
      idx_d    = IdxTop;
      tmo_d    = '0;
    end
  end

  always_comb begin
    busy    = (state_q == StReq);
    cmp_req = (state_q == StReq);
    trial   = (state_q == StReq) ? trial_w : '0;
    done    = done_q;
    result  = result_q;
    err     = err_q;
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Scoreboard bench for sar_search_ctrl against a behavioural comparator model.
module tb_sar_search_ctrl;

  localparam int unsigned W   = 8;
  localparam int unsigned TMO = 16;
`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         busy, done, err, cmp_req;
  logic [W-1:0] result, trial;
  logic         cmp_gt, cmp_eq, cmp_lt, cmp_valid;

  logic [W-1:0] x = '0;
  int           delay = 0;
  bit           stuck = 1'b0;
  bit           force_v = 1'b0;
  int           bad_at = -1;
  int           base = 0;
  int           wcnt;
  int           cmp_pos;
  int           cmp_total = 0;
  int           done_total = 0;
  int           checks = 0;
  int           errors = 0;

  logic [W-1:0] trial_sb[$];
  logic [W:0]   res_sb[$];

  always #5 clk = ~clk;

  sar_search_ctrl #(
    .WIDTH   (W),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err       (err),
    .trial     (trial),
    .cmp_req   (cmp_req),
    .cmp_gt    (cmp_gt),
    .cmp_eq    (cmp_eq),
    .cmp_lt    (cmp_lt),
    .cmp_valid (cmp_valid)
  );

  // Comparator model: wait counter per bit and count of completed compares.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt    <= 0;
      cmp_pos <= 0;
    end else if (cmp_req && cmp_valid) begin
      wcnt    <= 0;
      cmp_pos <= cmp_pos + 1;
    end else if (cmp_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  always_comb begin
    cmp_gt    = (x > trial);
    cmp_eq    = (x == trial);
    cmp_lt    = (x < trial);
    cmp_valid = force_v || (cmp_req && !stuck && wcnt >= delay);
    if (force_v || (bad_at >= 0 && (cmp_pos - base) == bad_at)) begin
      cmp_gt = 1'b1;
      cmp_eq = 1'b0;
      cmp_lt = 1'b1;
    end
  end

  // Monitor: pops expected trials on each compare and results on each done pulse.
  initial begin
    logic [W-1:0] texp, prev_trial;
    logic [W:0]   rexp;
    logic         prev_req, prev_valid;
    prev_req   = 1'b0;
    prev_valid = 1'b0;
    prev_trial = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cmp_req && prev_req && !prev_valid) begin
          checks++;
          if (trial !== prev_trial) begin
            errors++;
            $display("FAIL trial_stable: got %h want %h", trial, prev_trial);
          end
        end
        if (cmp_req && cmp_valid) begin
          cmp_total++;
          checks++;
          if (trial_sb.size() == 0) begin
            errors++;
            $display("FAIL extra_compare: got trial %h want no compare", trial);
          end else begin
            texp = trial_sb.pop_front();
            if (trial !== texp) begin
              errors++;
              $display("FAIL trial: got %h want %h", trial, texp);
            end
          end
        end
        if (done) begin
          done_total++;
          checks++;
          if (res_sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got result %h err %0b want no done", result, err);
          end else begin
            rexp = res_sb.pop_front();
            if ({err, result} !== rexp) begin
              errors++;
              $display("FAIL result: got err=%0b res=%h want err=%0b res=%h",
                       err, result, rexp[W], rexp[W-1:0]);
            end
          end
        end
        prev_req   = cmp_req;
        prev_valid = cmp_valid;
        prev_trial = trial;
      end else begin
        prev_req   = 1'b0;
        prev_valid = 1'b0;
      end
    end
  end

  // Reference binary search; pushes expected trials and result, returns compare count.
  task automatic model(input logic [W-1:0] xv, output int n);
    logic [W-1:0] acc, t;
    bit stop;
    acc  = '0;
    n    = 0;
    stop = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!stop) begin
        t = acc | (W'(1) << i);
        trial_sb.push_back(t);
        n++;
        if (EARLY && xv == t) begin
          acc  = t;
          stop = 1'b1;
        end else if (xv >= t) begin
          acc = t;
        end
      end
    end
    res_sb.push_back({1'b0, acc});
  endtask

  task automatic wait_done(inout int lat);
    while (!done && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_done: got no done after %0d cycles want done", lat);
    end
  endtask

  task automatic run_search(input logic [W-1:0] xv, input int dly);
    int n, lat, c0;
    x     = xv;
    delay = dly;
    model(xv, n);
    c0    = cmp_total;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    wait_done(lat);
    checks++;
    if (lat != 1 + n * (dly + 1)) begin
      errors++;
      $display("FAIL latency x=%h: got %0d want %0d", xv, lat, 1 + n * (dly + 1));
    end
    checks++;
    if (cmp_total - c0 != n) begin
      errors++;
      $display("FAIL compare_count x=%h: got %0d want %0d", xv, cmp_total - c0, n);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({busy, done, err, cmp_req, result, trial} !== '0) begin
      errors++;
      $display("FAIL %s: got busy=%0b done=%0b err=%0b req=%0b res=%h trial=%h want all 0",
               tag, busy, done, err, cmp_req, result, trial);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("post_reset");
    // Garbage compare results while idle must be ignored.
    force_v = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    force_v = 1'b0;
    check_idle_outputs("idle_valid_ignored");
  endtask

  task automatic test_basic();
    run_search(8'hA5, 0);
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 8'hA5) begin
      errors++;
      $display("FAIL done_hold: got done=%0b busy=%0b res=%h want 0 0 a5", done, busy, result);
    end
  endtask

  task automatic test_extremes();
    run_search(8'h00, 0);
    @(posedge clk);
    #1;
    run_search(8'hFF, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_early_exit();
    run_search(8'h80, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_delay();
    run_search(8'h3C, 3);
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    int lat, reqc;
    x     = 8'h37;
    delay = 0;
    stuck = 1'b1;
    res_sb.push_back({1'b1, 8'h00});
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    reqc  = 0;
    while (!done && lat < 200) begin
      if (cmp_req) reqc++;
      @(posedge clk);
      #1;
      lat++;
    end
    stuck = 1'b0;
    checks++;
    if (reqc != TMO || lat != TMO + 1 || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout: got wait=%0d lat=%0d err=%0b want wait=%0d lat=%0d err=1",
               reqc, lat, err, TMO, TMO + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_bad_code();
    int lat;
    x = 8'hA5;
    trial_sb.push_back(8'h80);
    trial_sb.push_back(8'hC0);
    trial_sb.push_back(8'hA0);
    res_sb.push_back({1'b1, 8'h80});
    base   = cmp_pos;
    bad_at = 2;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    wait_done(lat);
    bad_at = -1;
    checks++;
    if (lat != 4 || err !== 1'b1 || result !== 8'h80) begin
      errors++;
      $display("FAIL bad_code: got lat=%0d err=%0b res=%h want lat=4 err=1 res=80",
               lat, err, result);
    end
    @(posedge clk);
    #1;
    run_search(8'h5A, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int d0;
    x     = 8'hA5;
    delay = 0;
    trial_sb.push_back(8'h80);
    trial_sb.push_back(8'hC0);
    trial_sb.push_back(8'hA0);
    trial_sb.push_back(8'hB0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (trial !== 8'hA8 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bit3_trial: got trial=%h busy=%0b want a8 1", trial, busy);
    end
    d0    = done_total;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done_total != d0 || trial_sb.size() != 0) begin
      errors++;
      $display("FAIL reset_no_done: got dones=%0d pending=%0d want dones=%0d pending=0",
               done_total - d0 + d0, trial_sb.size(), d0);
    end
  endtask

  task automatic test_start_while_busy();
    int n, lat;
    x     = 8'h5A;
    delay = 0;
    model(8'h5A, n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 4;
    wait_done(lat);
    checks++;
    if (lat != 1 + n) begin
      errors++;
      $display("FAIL start_busy_latency: got %0d want %0d", lat, 1 + n);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1;
    run_search(8'h3C, 0);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_entry: got done=%0b want 1", done);
    end
    // Restart in the done-entry cycle; run_search checks it is accepted on time.
    run_search(8'hC3, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_early_exit();
    test_delay();
    test_timeout();
    test_bad_code();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    repeat (2) @(posedge clk);
    checks++;
    if (trial_sb.size() != 0 || res_sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got trials=%0d results=%0d want 0 0",
               trial_sb.size(), res_sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search controller: the other end of the 1-bit/N-bit magnitude comparator interface.
- Drives a trial value onto the comparator's B input while the unknown value X sits on its A input.
- Consumes the one-hot {A_great_B, A_equal_B, A_less_B} result and converges on X in at most WIDTH compares.
- Sits between a start/done requester and an external comparator, or a DAC plus analog comparator.

Parameters:
- WIDTH, 8, bit width of the searched value and trial bus.
- TIMEOUT, 16, maximum cycles to wait for cmp_valid per compare; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a search; accepted only in IDLE or DONE.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when a search ends, whether good or error.
- result  output  WIDTH  found value; held stable from done until the next accepted start.
- err  output  1  sticky error flag; valid with done; cleared on the next accepted start.
- trial  output  WIDTH  value presented to the comparator B input.
- cmp_req  output  1  trial valid; comparator must evaluate X vs trial.
- cmp_gt  input  1  X > trial.
- cmp_eq  input  1  X == trial.
- cmp_lt  input  1  X < trial.
- cmp_valid  input  1  cmp_gt/cmp_eq/cmp_lt are valid this cycle.

Behaviour:
- Reset: all outputs 0; state IDLE; bit index WIDTH-1; timeout counter 0.
- States:
  - IDLE/DONE -> REQ on start.
  - REQ -> REQ on the next bit.
  - REQ -> DONE on the last bit, error or timeout.
  - DONE: done=1 for exactly the entry cycle. The FSM then holds in DONE with done=0 until start.
- Accepted start:
  - result_acc=0, bit index i=WIDTH-1, err=0, busy=1.
  - cmp_req rises the next cycle with trial = result_acc | (1<<i).
- REQ handshake:
  - cmp_req and trial are held stable until a cycle with cmp_valid=1. That cycle completes bit i.
  - cmp_valid with cmp_req=0 is ignored.
- Per-bit decision:
  - gt or eq: keep bit i.
  - lt: clear bit i.
  - Then decrement i. The trial for bit i-1 appears the cycle after completion; cmp_req stays high between bits.
- Latency:
  - With cmp_valid tied high: first trial 1 cycle after start, then 1 cycle per bit.
  - done asserts WIDTH+1 cycles after start (without early exit).
- Completion of bit 0: result <= final accumulator, done=1, busy=0, cmp_req=0, trial=0.
- Invalid compare result: cmp_valid with {gt,eq,lt} not exactly one-hot.
  - err=1, done=1.
  - result = accumulator with bits below i cleared.
  - Search aborts.
- Timeout (TIMEOUT>0):
  - The counter counts REQ cycles with cmp_valid=0 and resets on each completed bit.
  - On reaching TIMEOUT: err=1, done=1, same abort as above.
- start while busy: ignored, no effect.
- start in the DONE-entry cycle: accepted; done still pulses.
- rst_n low mid-search: immediate return to reset values; no done pulse.
- All arithmetic is unsigned WIDTH bits; the bit index is $clog2(WIDTH) bits and never wraps below 0.

Optional Feature:
- Macro: SAR_EARLY_EXIT_EN.
- Defined: cmp_eq terminates the search at once. result=trial, done=1, and no further compares are issued.
- Undefined: eq is treated as gt and all WIDTH compares always run. The final result is identical; only the compare count differs.

Decomposition:
- Package sar_pkg:
  - state enum typedef (IDLE, REQ, DONE).
  - compare-result encoding constants: GT=3'b100, EQ=3'b010, LT=3'b001.
  - WIDTH-independent timeout counter width constant.
- Sub-module sar_cmp_decode: combinational decode of {gt,eq,lt} into keep, hit, bad (not one-hot). It is instantiated once.

Test Plan:
- X=0xA5, comparator model combinational, cmp_valid=1 -> trials 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; result=0xA5; err=0; done 9 cycles after start.
- X=0x00 and X=0xFF -> result 0x00 (all lt) and 0xFF (all gt, last eq); 8 compares each.
- X=0x80 with SAR_EARLY_EXIT_EN -> 1 compare, result=0x80; without the macro -> 8 compares, result=0x80.
- cmp_valid delayed 3 cycles per compare, TIMEOUT=16 -> trial/cmp_req stable during waits, result correct; with cmp_valid stuck low -> err=1, done at cycle 16 of the wait.
- gt and lt both asserted on bit 5 -> err=1, done pulse, result upper bits preserved and lower bits 0; next start clears err.
- rst_n pulsed low mid-search at bit 3 -> all outputs 0 immediately, no done; start while busy -> ignored.
